// File: rtl/neuron_mac.sv
// Weight-memory reader and multiply-accumulate for one neuron.
// Sweeps the shared weight/activation address range once per start and presents a saturated sum.
module neuron_mac #(
  parameter int numWeights   = 256,
  parameter int addressWidth = 8,
  parameter int dataWidth    = 6,
  parameter int sumWidth     = 10
) (
  input  logic                    clk,
  input  logic                    resetN,
  input  logic                    start,
  input  logic [sumWidth-1:0]     biasIn,
  output logic                    readEn,
  output logic [addressWidth-1:0] addr,
  input  logic [dataWidth-1:0]    weightIn,
  input  logic [dataWidth-1:0]    actIn,
  output logic                    busy,
  output logic                    done,
  output logic [sumWidth-1:0]     sumOut
);
  localparam int ACC_W  = 2*dataWidth + addressWidth + 2;
  localparam int PROD_W = 2*dataWidth + 1;
  localparam int HI_W   = ACC_W - sumWidth + 1;
  localparam logic [addressWidth-1:0] LAST = addressWidth'(numWeights - 1);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                    r_state, w_next;
  logic [addressWidth-1:0]   r_cnt;
  logic                      r_vld;
  logic signed [ACC_W-1:0]   r_acc;
  logic [sumWidth-1:0]       r_sum;
  logic                      r_done;
  logic                      w_read, w_accept;
  logic signed [PROD_W-1:0]  w_prod;
  logic signed [ACC_W-1:0]   w_prod_ext, w_sum;
  logic [HI_W-1:0]           w_hi;
  logic                      w_ovf;
  logic [sumWidth-1:0]       w_sat;

  // Weight is signed, activation unsigned: widen both to PROD_W so the product is exact.
  assign w_prod = $signed({{(dataWidth+1){weightIn[dataWidth-1]}}, weightIn})
                * $signed({{(dataWidth+1){1'b0}}, actIn});
  assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
  assign w_sum      = r_acc + (r_vld ? w_prod_ext : '0);

  // Fits in sumWidth only when every bit above the output sign bit equals it.
  assign w_hi  = w_sum[ACC_W-1:sumWidth-1];
  assign w_ovf = ~(&w_hi) & (|w_hi);
  assign w_sat = !w_ovf ? w_sum[sumWidth-1:0]
               : (w_sum[ACC_W-1] ? {1'b1, {(sumWidth-1){1'b0}}}
                                 : {1'b0, {(sumWidth-1){1'b1}}});

  always_ff @(posedge clk) begin
    if (!resetN) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_read   = 1'b0;
    w_accept = 1'b0;
    case (r_state)
      IDLE: if (start) begin
        w_accept = 1'b1;
        w_next   = READ;
      end
      READ: begin
        w_read = 1'b1;
        if (r_cnt == LAST) w_next = DRAIN;
      end
      DRAIN:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      r_cnt  <= '0;
      r_vld  <= 1'b0;
      r_acc  <= '0;
      r_sum  <= '0;
      r_done <= 1'b0;
    end else begin
      r_vld  <= w_read;
      r_done <= 1'b0;
      if (w_accept) begin
        r_acc <= {{(ACC_W-sumWidth){biasIn[sumWidth-1]}}, biasIn};
        r_cnt <= '0;
      end else begin
        r_acc <= w_sum;
        if (w_read && r_cnt != LAST) r_cnt <= r_cnt + 1'b1;
      end
      // DRAIN folds in the final product that arrives one cycle after the last read.
      if (r_state == DRAIN) begin
        r_sum  <= w_sat;
        r_done <= 1'b1;
      end
    end
  end

  assign readEn = w_read;
  assign addr   = w_read ? r_cnt : '0;
  assign busy   = (r_state != IDLE);
  assign done   = r_done;
  assign sumOut = r_sum;
endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac: a 256-weight instance and a 4-weight instance
// fed by registered memory models with one-cycle read latency.
module tb_neuron_mac;
  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  logic       b_start, b_readEn, b_busy, b_done;
  logic [9:0] b_bias, b_sum;
  logic [7:0] b_addr;
  logic [5:0] b_w, b_a;
  logic       s_start, s_readEn, s_busy, s_done;
  logic [9:0] s_bias, s_sum;
  logic [7:0] s_addr;
  logic [5:0] s_w, s_a;

  logic [5:0] bmw [256];
  logic [5:0] bma [256];
  logic [5:0] smw [4];
  logic [5:0] sma [4];

  int n_chk = 0;
  int n_bad = 0;

  neuron_mac u_big (
    .clk(clk), .resetN(resetN), .start(b_start), .biasIn(b_bias),
    .readEn(b_readEn), .addr(b_addr), .weightIn(b_w), .actIn(b_a),
    .busy(b_busy), .done(b_done), .sumOut(b_sum));

  neuron_mac #(.numWeights(4)) u_small (
    .clk(clk), .resetN(resetN), .start(s_start), .biasIn(s_bias),
    .readEn(s_readEn), .addr(s_addr), .weightIn(s_w), .actIn(s_a),
    .busy(s_busy), .done(s_done), .sumOut(s_sum));

  always @(posedge clk) begin
    if (b_readEn) begin b_w <= bmw[b_addr]; b_a <= bma[b_addr]; end
    if (s_readEn) begin s_w <= smw[s_addr[1:0]]; s_a <= sma[s_addr[1:0]]; end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic fill_big(input logic [5:0] w, input logic [5:0] a);
    for (int i = 0; i < 256; i++) begin bmw[i] = w; bma[i] = a; end
  endtask

  // One pass from a single start pulse; bias is scrambled right after capture.
  task automatic run_pass(input bit sm, input logic [9:0] bias, input logic [9:0] exp_sum,
                          input int n, input string tag);
    int nre, bad_addr, done_e, ndone, busy_bad;
    @(negedge clk);
    if (sm) begin s_start = 1'b1; s_bias = bias; end
    else    begin b_start = 1'b1; b_bias = bias; end
    @(posedge clk); #1;
    b_start = 1'b0; s_start = 1'b0;
    b_bias = ~bias; s_bias = ~bias;
    nre = 0; bad_addr = 0; done_e = -1; ndone = 0; busy_bad = 0;
    for (int e = 0; e < n + 10; e++) begin
      if (e > 0) begin @(posedge clk); #1; end
      if (sm ? s_readEn : b_readEn) begin
        if ((sm ? s_addr : b_addr) != nre[7:0]) bad_addr++;
        nre++;
      end
      if (sm ? s_done : b_done) begin
        ndone++;
        if (done_e < 0) begin
          done_e = e;
          if (sm ? s_busy : b_busy) busy_bad++;
        end
      end
    end
    chk({tag, "_rd_cycles"}, nre, n);
    chk({tag, "_addr_seq"}, bad_addr, 0);
    chk({tag, "_done_edge"}, done_e, n + 1);
    chk({tag, "_done_pulses"}, ndone, 1);
    chk({tag, "_busy_at_done"}, busy_bad, 0);
    chk({tag, "_sum"}, sm ? s_sum : b_sum, exp_sum);
  endtask

  initial begin
    int ea, abad, nd, sbad, follow_bad, guard, nd_rst;
    bit pd;
    resetN = 1'b0; b_start = 1'b0; s_start = 1'b0; b_bias = '0; s_bias = '0;
    smw[0] = 6'd1; smw[1] = 6'd2; smw[2] = 6'h3D; smw[3] = 6'd4;
    sma[0] = 6'd5; sma[1] = 6'd6; sma[2] = 6'd7;  sma[3] = 6'd1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_readEn", b_readEn, 0);
    chk("rst_addr", b_addr, 0);
    chk("rst_busy", b_busy, 0);
    chk("rst_done", b_done, 0);
    chk("rst_sum", b_sum, 0);
    @(negedge clk) resetN = 1'b1;

    // 256 * 1*1 = 256 fits in 10-bit signed
    fill_big(6'd1, 6'd1);
    run_pass(1'b0, 10'd0, 10'd256, 256, "ones");
    // 256 * (-1*3) = -768 clamps to -512
    fill_big(6'h3F, 6'd3);
    run_pass(1'b0, 10'd0, 10'h200, 256, "neg_sat");
    // 5 + 12 - 21 + 4 + bias 2 = 2
    run_pass(1'b1, 10'd2, 10'd2, 4, "small");

    // start held high: back-to-back passes with no address restart
    @(negedge clk); s_start = 1'b1; s_bias = 10'd2;
    ea = 0; abad = 0; nd = 0; sbad = 0; follow_bad = 0; pd = 1'b0;
    for (int e = 0; e < 20; e++) begin
      @(posedge clk); #1;
      if (pd && !s_readEn) follow_bad++;
      if (s_readEn) begin
        if (s_addr != ea[7:0]) abad++;
        ea = (ea + 1) % 4;
      end
      pd = s_done;
      if (s_done) begin nd++; if (s_sum != 10'd2) sbad++; end
    end
    s_start = 1'b0;
    chk("held_addr_seq", abad, 0);
    chk("held_passes", nd, 3);
    chk("held_sums", sbad, 0);
    chk("held_restart", follow_bad, 0);
    repeat (8) @(posedge clk);

    // reset while addr=100 aborts the pass
    fill_big(6'd2, 6'd2);
    @(negedge clk); b_start = 1'b1; b_bias = 10'd0;
    @(posedge clk); #1; b_start = 1'b0;
    guard = 0;
    while (b_addr != 8'd100 && guard < 300) begin @(posedge clk); #1; guard++; end
    chk("rst_reach_addr100", b_addr, 100);
    @(negedge clk) resetN = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy", b_busy, 0);
    chk("midrst_readEn", b_readEn, 0);
    chk("midrst_addr", b_addr, 0);
    chk("midrst_sum", b_sum, 0);
    @(negedge clk) resetN = 1'b1;
    nd_rst = 0;
    for (int e = 0; e < 300; e++) begin @(posedge clk); #1; if (b_done) nd_rst++; end
    chk("midrst_no_done", nd_rst, 0);

    // zero weights leave only the bias
    fill_big(6'd0, 6'd9);
    run_pass(1'b0, 10'h3F9, 10'h3F9, 256, "bias_only");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
